// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM states and
// instruction-word field positions.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_RST  = 4'b0001;
    localparam logic [3:0] OP_LDI  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NAND = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NOT  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam int REG_AW  = 4;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes that go through the external ALU (EXEC/WB path).
    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NAND, OP_NOR, OP_NOT: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Instruction handshake, ALU operand/result bus, write-back and debug port
// of the ALU issue stage.
interface alu_issue_seq_if import alu_pkg::*; #(parameter int WIDTH = 16);

    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr_word;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [3:0]        alu_op;
    logic [WIDTH-1:0]  alu_result;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              illegal;
    logic [REG_AW-1:0] dbg_addr;
    logic [WIDTH-1:0]  dbg_data;

    modport slave (
        input  instr_valid, instr_word, alu_result, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op,
               wb_valid, wb_addr, wb_data, illegal, dbg_data
    );

    modport master (
        output instr_valid, instr_word, alu_result, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op,
               wb_valid, wb_addr, wb_data, illegal, dbg_data
    );

endinterface

// File: rtl/alu_regfile.sv
// Register file: two combinational operand reads, one debug read, one
// synchronous write port and a synchronous clear-all.
module alu_regfile import alu_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic [WIDTH-1:0]  dbg_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr
);

    logic [WIDTH-1:0] mem [NREGS];

    // One flop bank per register so the whole file can reset and clear at once.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem[gi] <= '0;
                end else if (clr) begin
                    mem[gi] <= '0;
                end else if (wr_en && (wr_addr == REG_AW'(gi))) begin
                    mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];
    assign dbg_data  = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue stage for the 16-bit ALU: decodes one instruction at a time, drives
// registered operands to the ALU and writes the captured result back.
module alu_issue_seq import alu_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_seq_if.slave  bus
);

    state_t state_reg, state_next;

    logic [3:0]        op;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [7:0]        imm;
    logic [WIDTH-1:0]  imm_ext;

    logic [WIDTH-1:0]  rs1_data, rs2_data;
    logic [WIDTH-1:0]  alu_a_reg, alu_b_reg, result_reg, wb_data_reg;
    logic [3:0]        alu_op_reg;
    logic [REG_AW-1:0] rd_reg, wb_addr_reg;
    logic              wb_valid_reg, illegal_reg;

    logic              handshake;
    logic              rf_we, rf_clr, load_ops, wb_set, illegal_set;
    logic [REG_AW-1:0] rf_waddr, wb_addr_next;
    logic [WIDTH-1:0]  rf_wdata, wb_data_next;

    assign op      = bus.instr_word[OP_MSB:OP_LSB];
    assign rd      = bus.instr_word[RD_MSB:RD_LSB];
    assign rs1     = bus.instr_word[RS1_MSB:RS1_LSB];
    assign rs2     = bus.instr_word[RS2_MSB:RS2_LSB];
    assign imm     = bus.instr_word[IMM_MSB:IMM_LSB];
    assign imm_ext = WIDTH'(imm);

    assign bus.instr_ready = (state_reg == S_IDLE);
    assign handshake       = bus.instr_valid && (state_reg == S_IDLE);

    alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1),
        .rd_addr_b (rs2),
        .dbg_addr  (bus.dbg_addr),
        .rd_data_a (rs1_data),
        .rd_data_b (rs2_data),
        .dbg_data  (bus.dbg_data),
        .wr_en     (rf_we),
        .wr_addr   (rf_waddr),
        .wr_data   (rf_wdata),
        .clr       (rf_clr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rf_we        = 1'b0;
        rf_clr       = 1'b0;
        rf_waddr     = rd_reg;
        rf_wdata     = result_reg;
        load_ops     = 1'b0;
        wb_set       = 1'b0;
        wb_addr_next = rd_reg;
        wb_data_next = result_reg;
        illegal_set  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (handshake) begin
                    if (is_alu_op(op)) begin
                        load_ops   = 1'b1;
                        state_next = S_EXEC;
                    end else begin
                        case (op)
                            OP_NOP: begin
                            end
                            OP_RST: begin
                                rf_clr       = 1'b1;
                                wb_set       = 1'b1;
                                wb_addr_next = '0;
                                wb_data_next = '0;
                            end
                            OP_LDI: begin
                                rf_we        = 1'b1;
                                rf_waddr     = rd;
                                rf_wdata     = imm_ext;
                                wb_set       = 1'b1;
                                wb_addr_next = rd;
                                wb_data_next = imm_ext;
                            end
                            default: illegal_set = 1'b1;
                        endcase
                    end
                end
            end
            S_EXEC: state_next = S_WB;
            S_WB: begin
                rf_we      = 1'b1;
                wb_set     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operands hold their last value between ops; only a new ALU op reloads them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_reg       <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= OP_NOP;
            result_reg   <= '0;
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= '0;
            wb_data_reg  <= '0;
            illegal_reg  <= 1'b0;
        end else begin
            if (load_ops) begin
                rd_reg     <= rd;
                alu_a_reg  <= rs1_data;
                alu_b_reg  <= (op == OP_NOT) ? '0 : rs2_data;
                alu_op_reg <= op;
            end
            if (state_reg == S_EXEC) begin
                result_reg <= bus.alu_result;
            end
            wb_valid_reg <= wb_set;
            illegal_reg  <= illegal_set;
            if (wb_set) begin
                wb_addr_reg <= wb_addr_next;
                wb_data_reg <= wb_data_next;
            end
        end
    end

    assign bus.alu_a    = alu_a_reg;
    assign bus.alu_b    = alu_b_reg;
    assign bus.alu_op   = alu_op_reg;
    assign bus.wb_valid = wb_valid_reg;
    assign bus.wb_addr  = wb_addr_reg;
    assign bus.wb_data  = wb_data_reg;
    assign bus.illegal  = illegal_reg;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: vector table for single instructions plus
// hand-written back-to-back and reset-abort sequences.
module tb_alu_issue_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_seq_if #(.WIDTH(16)) bus ();

    alu_issue_seq #(.WIDTH(16), .NREGS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU, combinational on the issued operands.
    always_comb begin
        bus.alu_result = 16'h0000;
        case (bus.alu_op)
            4'h4: bus.alu_result = bus.alu_a + bus.alu_b;
            4'h5: bus.alu_result = bus.alu_a - bus.alu_b;
            4'h8: bus.alu_result = bus.alu_a & bus.alu_b;
            4'h9: bus.alu_result = bus.alu_a | bus.alu_b;
            4'hA: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'hB: bus.alu_result = ~(bus.alu_a & bus.alu_b);
            4'hC: bus.alu_result = ~(bus.alu_a | bus.alu_b);
            4'hD: bus.alu_result = ~bus.alu_a;
            default: bus.alu_result = 16'h0000;
        endcase
    end

    typedef struct {
        logic [15:0] word;
        logic        exp_wb;
        logic [3:0]  exp_addr;
        logic [15:0] exp_data;
        logic        exp_ill;
        logic [3:0]  dbg_addr;
        logic [15:0] exp_dbg;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [15:0] w, input logic wb, input logic [3:0] a,
                                input logic [15:0] d, input logic ill,
                                input logic [3:0] da, input logic [15:0] dd);
        vec_t v;
        v.word = w; v.exp_wb = wb; v.exp_addr = a; v.exp_data = d;
        v.exp_ill = ill; v.dbg_addr = da; v.exp_dbg = dd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a word and wait (bounded) for it to be accepted; returns right after the accepting edge.
    task automatic send(input logic [15:0] w, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_word  = w;
        for (int i = 0; i < 10; i++) begin
            if (bus.instr_ready) begin
                @(posedge clk);
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout word=0x%04h: instr_ready never high, expected within 10 cycles", w);
        bus.instr_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit ok, seen_wb, seen_ill;
        logic [3:0]  got_addr;
        logic [15:0] got_data;
        seen_wb = 1'b0; seen_ill = 1'b0; got_addr = '0; got_data = '0;
        send(v.word, ok);
        if (!ok) return;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) bus.instr_valid = 1'b0;
            if (bus.wb_valid) begin
                seen_wb  = 1'b1;
                got_addr = bus.wb_addr;
                got_data = bus.wb_data;
            end
            if (bus.illegal) seen_ill = 1'b1;
        end
        check($sformatf("wb_valid[%04h]", v.word), 32'(seen_wb), 32'(v.exp_wb));
        if (v.exp_wb) begin
            check($sformatf("wb_addr[%04h]", v.word), 32'(got_addr), 32'(v.exp_addr));
            check($sformatf("wb_data[%04h]", v.word), 32'(got_data), 32'(v.exp_data));
        end
        check($sformatf("illegal[%04h]", v.word), 32'(seen_ill), 32'(v.exp_ill));
        if (v.word[15:12] == 4'hD)
            check($sformatf("not_alu_b[%04h]", v.word), 32'(bus.alu_b), 32'h0);
        bus.dbg_addr = v.dbg_addr;
        #1;
        check($sformatf("dbg r%0d[%04h]", v.dbg_addr, v.word), 32'(bus.dbg_data), 32'(v.exp_dbg));
        $display("vec word=0x%04h wb=%0d addr=%0d data=0x%04h ill=%0d dbg=0x%04h",
                 v.word, seen_wb, got_addr, got_data, seen_ill, bus.dbg_data);
    endtask

    initial begin
        bit ok, saw;
        logic [15:0] b2b [3];
        int acc, wbn, last_wb, rdy_hi;
        bit hs;

        bus.instr_valid = 1'b0;
        bus.instr_word  = 16'h0000;
        bus.dbg_addr    = 4'd5;

        tbl.push_back(mk(16'h2134, 1'b1, 4'd1,  16'h0034, 1'b0, 4'd1,  16'h0034));
        tbl.push_back(mk(16'h2212, 1'b1, 4'd2,  16'h0012, 1'b0, 4'd2,  16'h0012));
        tbl.push_back(mk(16'h4312, 1'b1, 4'd3,  16'h0046, 1'b0, 4'd3,  16'h0046));
        tbl.push_back(mk(16'h2101, 1'b1, 4'd1,  16'h0001, 1'b0, 4'd1,  16'h0001));
        tbl.push_back(mk(16'h5401, 1'b1, 4'd4,  16'hFFFF, 1'b0, 4'd4,  16'hFFFF));
        tbl.push_back(mk(16'hD544, 1'b1, 4'd5,  16'h0000, 1'b0, 4'd5,  16'h0000));
        tbl.push_back(mk(16'h21F0, 1'b1, 4'd1,  16'h00F0, 1'b0, 4'd1,  16'h00F0));
        tbl.push_back(mk(16'h22FF, 1'b1, 4'd2,  16'h00FF, 1'b0, 4'd2,  16'h00FF));
        tbl.push_back(mk(16'h4222, 1'b1, 4'd2,  16'h01FE, 1'b0, 4'd2,  16'h01FE));
        tbl.push_back(mk(16'h4222, 1'b1, 4'd2,  16'h03FC, 1'b0, 4'd2,  16'h03FC));
        tbl.push_back(mk(16'h4222, 1'b1, 4'd2,  16'h07F8, 1'b0, 4'd2,  16'h07F8));
        tbl.push_back(mk(16'h4222, 1'b1, 4'd2,  16'h0FF0, 1'b0, 4'd2,  16'h0FF0));
        tbl.push_back(mk(16'h8812, 1'b1, 4'd8,  16'h00F0, 1'b0, 4'd8,  16'h00F0));
        tbl.push_back(mk(16'h9912, 1'b1, 4'd9,  16'h0FF0, 1'b0, 4'd9,  16'h0FF0));
        tbl.push_back(mk(16'hAA12, 1'b1, 4'd10, 16'h0F00, 1'b0, 4'd10, 16'h0F00));
        tbl.push_back(mk(16'hBB12, 1'b1, 4'd11, 16'hFF0F, 1'b0, 4'd11, 16'hFF0F));
        tbl.push_back(mk(16'hCC12, 1'b1, 4'd12, 16'hF00F, 1'b0, 4'd12, 16'hF00F));
        tbl.push_back(mk(16'h7123, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd1,  16'h00F0));
        tbl.push_back(mk(16'h3456, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd4,  16'hFFFF));
        tbl.push_back(mk(16'hE000, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd1,  16'h00F0));
        tbl.push_back(mk(16'hF2FF, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd2,  16'h0FF0));
        tbl.push_back(mk(16'h6A12, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd10, 16'h0F00));
        tbl.push_back(mk(16'h0AAA, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd10, 16'h0F00));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst instr_ready", 32'(bus.instr_ready), 32'h1);
        check("rst wb_valid",    32'(bus.wb_valid),    32'h0);
        check("rst illegal",     32'(bus.illegal),     32'h0);
        check("rst alu_a",       32'(bus.alu_a),       32'h0);
        check("rst alu_b",       32'(bus.alu_b),       32'h0);
        check("rst alu_op",      32'(bus.alu_op),      32'h0);
        check("rst wb_addr",     32'(bus.wb_addr),     32'h0);
        check("rst wb_data",     32'(bus.wb_data),     32'h0);
        check("rst dbg r5",      32'(bus.dbg_data),    32'h0);
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Back-to-back ADDs with instr_valid held high
        b2b[0] = 16'h4D12; b2b[1] = 16'h4E12; b2b[2] = 16'h4F12;
        acc = 0; wbn = 0; last_wb = -1; rdy_hi = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_word  = b2b[0];
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (bus.wb_valid) begin
                check($sformatf("b2b wb_data #%0d", wbn), 32'(bus.wb_data), 32'h10E0);
                check($sformatf("b2b wb_addr #%0d", wbn), 32'(bus.wb_addr), 32'(13 + wbn));
                if (last_wb >= 0)
                    check($sformatf("b2b wb spacing #%0d", wbn), 32'(cyc - last_wb), 32'd3);
                last_wb = cyc;
                wbn++;
            end
            if (cyc < 9 && bus.instr_ready) rdy_hi++;
            hs = bus.instr_valid && bus.instr_ready;
            @(posedge clk);
            if (hs) acc++;
            @(negedge clk);
            if (acc < 3) bus.instr_word = b2b[acc];
            else         bus.instr_valid = 1'b0;
        end
        check("b2b accepted", 32'(acc), 32'd3);
        check("b2b wb count", 32'(wbn), 32'd3);
        check("b2b ready cycles of 9", 32'(rdy_hi), 32'd3);
        $display("b2b accepted=%0d wb=%0d ready_hi=%0d", acc, wbn, rdy_hi);

        // Reset asserted during EXEC aborts the ADD
        send(16'h4312, ok);
        if (ok) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            rst = 1'b1;
            bus.dbg_addr = 4'd1;
            #1;
            check("abort ready in rst", 32'(bus.instr_ready), 32'h1);
            check("abort dbg r1 in rst", 32'(bus.dbg_data), 32'h0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            saw = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (bus.wb_valid) saw = 1'b1;
            end
            check("abort no wb_valid", 32'(saw), 32'h0);
            bus.dbg_addr = 4'd3;
            #1;
            check("abort dbg r3", 32'(bus.dbg_data), 32'h0);
            check("abort ready after", 32'(bus.instr_ready), 32'h1);
            $display("abort wb_seen=%0d r3=0x%04h", saw, bus.dbg_data);
        end

        // RST op clears registers
        run_vec(mk(16'h27AA, 1'b1, 4'd7, 16'h00AA, 1'b0, 4'd7, 16'h00AA));
        run_vec(mk(16'h1000, 1'b1, 4'd0, 16'h0000, 1'b0, 4'd7, 16'h0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, expected completion");
        $fatal(1, "timeout");
    end

endmodule
